comm_master: RTL and testbench

- UART command transmitter used in the maze-runner system bench.
- On request, sends one 16-bit travel-plan command word over a single serial TX line as two back-to-back 8N1 UART frames, high byte first.
- Drives the RX input of the maze-runner top level.
- Reports completion on a level-held flag.

---
 rtl/maze_pkg.sv | 13 +
 rtl/uart_tx.sv | 59 +++++
 rtl/comm_master.sv | 83 ++++++++
 tb/tb_comm_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze-runner command path: default bit timing
// and the command transmitter state encoding.
package maze_pkg;

    localparam int unsigned BAUD_DIV_DEF = 2604;  // 50 MHz / 19200 baud

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first. A trmt pulse loads a byte and drives the
// start bit on the next edge; tx_done pulses for one clock as the stop bit ends.
module uart_tx
    import maze_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic          busy;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;
    logic          baud_tc;

    assign baud_tc = busy && (baud_cnt == BW'(BAUD_DIV - 1));
    assign tx_done = baud_tc && (bit_cnt == 4'd9);

    // trmt wins over tx_done so a following frame starts with no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            TX       <= 1'b1;
        end else if (trmt) begin
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= {1'b1, tx_data};
            TX       <= 1'b0;
        end else if (busy) begin
            if (baud_tc) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    TX      <= 1'b1;
                end else begin
                    TX      <= shift[0];
                    shift   <= {1'b1, shift[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/comm_master.sv
// Sends a 16-bit command as two back-to-back UART frames, high byte first,
// and holds cmd_cmplt high once the low byte has left the wire.
module comm_master
    import maze_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        TX,
    output logic        cmd_cmplt
);

    state_t     state;
    state_t     nxt_state;
    logic [7:0] low_byte;
    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;
    logic       accept;
    logic       set_cmplt;

    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // trmt is combinational so the start bit follows acceptance by one edge.
    always_comb begin
        nxt_state = state;
        trmt      = 1'b0;
        tx_data   = cmd[15:8];
        accept    = 1'b0;
        set_cmplt = 1'b0;
        case (state)
            IDLE: begin
                if (snd_cmd) begin
                    accept    = 1'b1;
                    trmt      = 1'b1;
                    nxt_state = HIGH;
                end
            end
            HIGH: begin
                tx_data = low_byte;
                if (tx_done) begin
                    trmt      = 1'b1;
                    nxt_state = LOW;
                end
            end
            LOW: begin
                if (tx_done) begin
                    set_cmplt = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_byte  <= '0;
            cmd_cmplt <= 1'b0;
        end else if (accept) begin
            low_byte  <= cmd[7:0];
            cmd_cmplt <= 1'b0;
        end else if (set_cmplt) begin
            cmd_cmplt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master: a software UART receiver decodes TX and
// compares each byte against a queue of bytes pushed when commands are sent.
module tb_comm_master;

    localparam int unsigned B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        TX;
    logic        cmd_cmplt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned last_start = 0;
    logic [7:0]  sbq[$];

    comm_master #(.BAUD_DIV(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .snd_cmd   (snd_cmd),
        .cmd       (cmd),
        .TX        (TX),
        .cmd_cmplt (cmd_cmplt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int unsigned v,
                             input int unsigned lo, input int unsigned hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic send(input logic [15:0] v, input bit push);
        @(negedge clk);
        cmd     = v;
        snd_cmd = 1'b1;
        if (push) begin
            sbq.push_back(v[15:8]);
            sbq.push_back(v[7:0]);
        end
        @(negedge clk);
        snd_cmd = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic rx_frame(input string tag);
        int unsigned n;
        logic [7:0]  b;
        logic [7:0]  exp;
        logic        sb;
        logic        pb;
        n = 0;
        while (TX !== 1'b0 && n < 40 * B) begin
            @(negedge clk);
            n++;
        end
        exp = (sbq.size() > 0) ? sbq.pop_front() : 8'hxx;
        if (TX !== 1'b0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        last_start = cyc;
        repeat (B / 2) @(negedge clk);
        sb = TX;
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            b[i] = TX;
        end
        repeat (B) @(negedge clk);
        pb = TX;
        chk({tag, "_start"}, {31'd0, sb}, 32'd0);
        chk({tag, "_data"}, {24'd0, b}, {24'd0, exp});
        chk({tag, "_stop"}, {31'd0, pb}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int unsigned n;
        n = 0;
        while (cmd_cmplt !== 1'b1 && n < 4 * B) begin
            @(negedge clk);
            n++;
        end
        chk_range({tag, "_cmplt_latency"}, cyc - acc_cyc, 20 * B, 20 * B + 2);
    endtask

    initial begin
        int unsigned lows;
        int unsigned drops;
        int unsigned run;
        int unsigned maxrun;
        int unsigned pulses;
        int unsigned starts[6];
        int unsigned n;
        bit          done;

        // Reset and idle line
        repeat (5) @(negedge clk);
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_cmplt", {31'd0, cmd_cmplt}, 32'd0);
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        chk("idle_tx_low_count", lows, 32'd0);

        // Single command
        send(16'hA5C3, 1'b1);
        rx_frame("single_hi");
        rx_frame("single_lo");
        wait_done("single");
        drops = 0;
        repeat (10 * B) begin
            @(negedge clk);
            if (cmd_cmplt !== 1'b1) drops++;
        end
        chk("cmplt_hold_drops", drops, 32'd0);

        // cmd changes mid-frame must not reach the wire
        send(16'h5555, 1'b1);
        fork
            begin
                rx_frame("stab_hi");
                rx_frame("stab_lo");
            end
            begin
                repeat (3 * B) @(negedge clk);
                cmd = 16'hFFFF;
            end
        join
        wait_done("stab");

        // Boundary data patterns
        send(16'h0000, 1'b1);
        rx_frame("zero_hi");
        rx_frame("zero_lo");
        wait_done("zero");
        send(16'hFFFF, 1'b1);
        rx_frame("ones_hi");
        rx_frame("ones_lo");
        wait_done("ones");

        // Continuous request: three transfers, then release
        @(negedge clk);
        cmd     = 16'h002D;
        snd_cmd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back(8'h00);
            sbq.push_back(8'h2D);
        end
        done   = 1'b0;
        run    = 0;
        maxrun = 0;
        pulses = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    rx_frame("cont");
                    starts[i] = last_start;
                end
                snd_cmd = 1'b0;
                done    = 1'b1;
            end
            begin
                @(negedge clk);
                while (!done) begin
                    if (cmd_cmplt === 1'b1) begin
                        run++;
                    end else begin
                        if (run > 0) begin
                            pulses++;
                            if (run > maxrun) maxrun = run;
                        end
                        run = 0;
                    end
                    @(negedge clk);
                end
            end
        join
        for (int i = 0; i < 5; i++)
            chk_range("cont_frame_spacing", starts[i+1] - starts[i], 10 * B, 10 * B + 2);
        chk("cont_cmplt_pulses", pulses, 32'd2);
        chk_range("cont_cmplt_width", maxrun, 1, 2);
        n = 0;
        while (cmd_cmplt !== 1'b1 && n < 4 * B) begin
            @(negedge clk);
            n++;
        end
        chk("cont_final_cmplt", {31'd0, cmd_cmplt}, 32'd1);

        // Abort during high-byte data bit 4 (0xA5 bit 4 is 0)
        send(16'hA5C3, 1'b0);
        repeat (5 * B + B / 2 - 1) @(negedge clk);
        chk("abort_pre_tx", {31'd0, TX}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_tx", {31'd0, TX}, 32'd1);
        chk("abort_cmplt", {31'd0, cmd_cmplt}, 32'd0);
        cmd     = 16'h3C96;
        snd_cmd = 1'b1;
        sbq.push_back(8'h3C);
        sbq.push_back(8'h96);
        repeat (3) @(negedge clk);
        chk("abort_hold_tx", {31'd0, TX}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        acc_cyc = cyc;
        rx_frame("fresh_hi");
        rx_frame("fresh_lo");
        wait_done("fresh");
        chk("sb_empty", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
